// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: assembles SOF/CMD/LEN/PAYLOAD/CHK frames from the UART byte strobe,
// presents good frames on a valid/ready handshake and pulses an error flag for each discarded frame.
module uart_frame_decoder #(
    parameter logic [7:0]  SOF_BYTE     = 8'hAA,
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned TIMEOUT_CLKS = 104170
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_vd,
    input  logic [7:0]             rx_data,
    output logic                   frm_valid,
    input  logic                   frm_ready,
    output logic [7:0]             frm_cmd,
    output logic [3:0]             frm_len,
    output logic [8*MAX_LEN-1:0]   frm_payload,
    output logic                   err_chk,
    output logic                   err_len,
    output logic                   err_to,
    output logic                   ovf
);

    localparam int unsigned      CNT_W     = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [3:0]           len_q, len_d;
    logic [8*MAX_LEN-1:0] pl_q, pl_d;
    logic [7:0]           chk_q, chk_d;
    logic [3:0]           idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_chk_d, err_len_d, err_to_d, ovf_d;
    logic                 in_frame;

    assign frm_valid   = (state_q == S_HOLD);
    assign frm_cmd     = cmd_q;
    assign frm_len     = len_q;
    assign frm_payload = pl_q;

    // Next-state, datapath updates and error pulse requests for the frame parser.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        pl_d      = pl_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        cnt_d     = '0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        ovf_d     = 1'b0;
        in_frame  = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);

        case (state_q)
            S_HUNT: begin
                if (rx_vd && (rx_data == SOF_BYTE)) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_vd) begin
                    cmd_d   = rx_data;
                    chk_d   = rx_data;
                    pl_d    = '0;
                    idx_d   = '0;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_vd) begin
                    len_d = rx_data[3:0];
                    chk_d = chk_q ^ rx_data;
                    if (rx_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else if (rx_data == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_vd) begin
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 4'(i)) begin
                            pl_d[8*i +: 8] = rx_data;
                        end
                    end
                    chk_d = chk_q ^ rx_data;
                    idx_d = idx_q + 4'd1;
                    if ((idx_q + 4'd1) == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_vd) begin
                    if (rx_data == chk_q) begin
                        state_d = S_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                if (rx_vd) begin
                    ovf_d = 1'b1;
                end
                if (frm_ready) begin
                    state_d = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // A strobe in the timeout clk keeps the frame alive, so only idle clks count.
        if (in_frame && !rx_vd) begin
            if (cnt_q == CNT_LAST) begin
                err_to_d = 1'b1;
                state_d  = S_HUNT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State, frame fields, checksum, timeout counter and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HUNT;
            cmd_q   <= '0;
            len_q   <= '0;
            pl_q    <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_to  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            pl_q    <= pl_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_chk <= err_chk_d;
            err_len <= err_len_d;
            err_to  <= err_to_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed scenarios plus random frames checked against a frame-level model.
module tb_uart_frame_decoder;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TO_CLKS = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rx_vd;
    logic [7:0]           rx_data;
    logic                 frm_valid;
    logic                 frm_ready;
    logic [7:0]           frm_cmd;
    logic [3:0]           frm_len;
    logic [8*MAX_LEN-1:0] frm_payload;
    logic                 err_chk, err_len, err_to, ovf;

    int total = 0;
    int bad   = 0;
    logic [7:0] txq[$];

    uart_frame_decoder #(
        .SOF_BYTE    (8'hAA),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CLKS(TO_CLKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_vd      (rx_vd),
        .rx_data    (rx_data),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_cmd    (frm_cmd),
        .frm_len    (frm_len),
        .frm_payload(frm_payload),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_to     (err_to),
        .ovf        (ovf)
    );

    // 100MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_vd   = 1'b1;
        rx_data = b;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_vd = 1'b0;
        end
    endtask

    task automatic send_q(input int maxgap);
        for (int i = 0; i < txq.size(); i++) begin
            put(txq[i]);
            if (i != txq.size() - 1) gap($urandom_range(0, maxgap));
        end
        gap(1);
    endtask

    task automatic check_idle_errs(input string tag);
        check({tag, "_errchk"}, 64'(err_chk), 64'd0);
        check({tag, "_errlen"}, 64'(err_len), 64'd0);
        check({tag, "_errto"},  64'(err_to),  64'd0);
        check({tag, "_ovf"},    64'(ovf),     64'd0);
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
        check({tag, "_drop"}, 64'(frm_valid), 64'd0);
    endtask

    task automatic load_t1;
        txq = '{8'hAA, 8'h10, 8'h02, 8'h55, 8'h66, 8'h21};
    endtask

    task automatic check_t1(input string tag);
        check({tag, "_valid"}, 64'(frm_valid), 64'd1);
        check({tag, "_cmd"},   64'(frm_cmd),   64'h10);
        check({tag, "_len"},   64'(frm_len),   64'd2);
        check({tag, "_pl"},    frm_payload,    64'h6655);
    endtask

    initial begin
        int         cycles;
        int         kind;
        int         ng;
        int         hold;
        logic [7:0] c, l, x, b, ck;
        logic [63:0] exp_pl;

        rst = 1'b1; rx_vd = 1'b0; rx_data = '0; frm_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(frm_valid), 64'd0);
        check("rst_cmd",   64'(frm_cmd),   64'd0);
        check("rst_len",   64'(frm_len),   64'd0);
        check("rst_pl",    frm_payload,    64'd0);
        check_idle_errs("rst");
        rst = 1'b0;

        // 1: good frame, back-to-back bytes
        load_t1(); send_q(0);
        check_t1("t1");
        check_idle_errs("t1");
        accept("t1");
        check("t1_keepcmd", 64'(frm_cmd), 64'h10);
        check("t1_keeppl",  frm_payload,  64'h6655);

        // 2: bad checksum then good frame
        txq = '{8'hAA, 8'h10, 8'h02, 8'h55, 8'h66, 8'h22}; send_q(2);
        check("t2_errchk", 64'(err_chk),   64'd1);
        check("t2_valid",  64'(frm_valid), 64'd0);
        gap(1);
        check("t2_pulse",  64'(err_chk),   64'd0);
        load_t1(); send_q(2);
        check_t1("t2b");
        accept("t2b");

        // 3: oversize length; trailing bytes ignored
        txq = '{8'hAA, 8'h10, 8'h09}; send_q(0);
        check("t3_errlen", 64'(err_len),   64'd1);
        check("t3_valid",  64'(frm_valid), 64'd0);
        txq = '{8'h33, 8'h44}; send_q(0);
        check("t3_ign_valid", 64'(frm_valid), 64'd0);
        check_idle_errs("t3_ign");
        load_t1(); send_q(1);
        check_t1("t3b");
        accept("t3b");

        // 4: inter-byte timeout
        txq = '{8'hAA, 8'h10}; send_q(0);
        cycles = 0;
        while (err_to !== 1'b1 && cycles < 2 * TO_CLKS) begin
            @(negedge clk);
            cycles++;
        end
        check("t4_to_clks", 64'(cycles),    64'(TO_CLKS));
        check("t4_valid",   64'(frm_valid), 64'd0);
        gap(1);
        check("t4_pulse",   64'(err_to),    64'd0);

        // 5: overflow while holding, including the accept clk
        load_t1(); send_q(0);
        check_t1("t5");
        put(8'hAA); gap(1);
        check("t5_ovf", 64'(ovf), 64'd1);
        check_t1("t5_held");
        gap(1);
        check("t5_ovf_pulse", 64'(ovf), 64'd0);
        @(negedge clk);
        frm_ready = 1'b1; rx_vd = 1'b1; rx_data = 8'hAA;
        @(negedge clk);
        frm_ready = 1'b0; rx_vd = 1'b0;
        check("t5_acc_valid", 64'(frm_valid), 64'd0);
        check("t5_acc_ovf",   64'(ovf),       64'd1);
        txq = '{8'h10, 8'h02, 8'h55, 8'h66, 8'h21}; send_q(0);
        check("t5_nosof", 64'(frm_valid), 64'd0);

        // 6: reset mid-payload, then empty-payload frame after garbage
        txq = '{8'hAA, 8'h10, 8'h02, 8'h55}; send_q(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid", 64'(frm_valid), 64'd0);
        check("t6_cmd",   64'(frm_cmd),   64'd0);
        check("t6_len",   64'(frm_len),   64'd0);
        check("t6_pl",    frm_payload,    64'd0);
        gap(1);
        check_idle_errs("t6");
        txq = '{8'h00, 8'hFF, 8'hAA, 8'h05, 8'h00, 8'h05}; send_q(0);
        check("t6b_valid", 64'(frm_valid), 64'd1);
        check("t6b_cmd",   64'(frm_cmd),   64'h05);
        check("t6b_len",   64'(frm_len),   64'd0);
        check("t6b_pl",    frm_payload,    64'd0);
        accept("t6b");

        // Random frames: 0/1 good, 2 bad checksum, 3 oversize length.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            c = 8'($urandom);
            l = (kind == 3) ? 8'($urandom_range(MAX_LEN + 1, 255)) : 8'($urandom_range(0, MAX_LEN));
            txq.delete();
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                b = 8'($urandom);
                if (b == 8'hAA) b = 8'h00;
                txq.push_back(b);
            end
            txq.push_back(8'hAA);
            txq.push_back(c);
            txq.push_back(l);
            x = c ^ l;
            exp_pl = '0;
            if (kind != 3) begin
                for (int i = 0; i < int'(l); i++) begin
                    b = 8'($urandom);
                    txq.push_back(b);
                    x = x ^ b;
                    exp_pl = exp_pl + (64'(b) << (8 * i));
                end
                ck = (kind == 2) ? (x ^ 8'($urandom_range(1, 255))) : x;
                txq.push_back(ck);
            end
            send_q(4);
            if (kind == 3) begin
                check("rnd_errlen", 64'(err_len),   64'd1);
                check("rnd_lvalid", 64'(frm_valid), 64'd0);
            end else if (kind == 2) begin
                check("rnd_errchk", 64'(err_chk),   64'd1);
                check("rnd_cvalid", 64'(frm_valid), 64'd0);
            end else begin
                check("rnd_valid", 64'(frm_valid), 64'd1);
                check("rnd_cmd",   64'(frm_cmd),   64'(c));
                check("rnd_len",   64'(frm_len),   64'(l));
                check("rnd_pl",    frm_payload,    exp_pl);
                check_idle_errs("rnd");
                hold = $urandom_range(0, 3);
                repeat (hold) @(negedge clk);
                check("rnd_hold", 64'(frm_valid), 64'd1);
                check("rnd_hpl",  frm_payload,    exp_pl);
                accept("rnd");
            end
            gap(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
